// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - CPU load/store to Avalon-style data memory bus master
`timescale 1ns/1ps
// Converts one CPU byte/half/word access into a single aligned word transaction,
// honours waitrequest and a fixed read latency, and returns the lane-extracted,
// sign/zero-extended load result. Misaligned or reserved-size requests are
// answered with an error response without touching the bus.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   req_*           CPU request (req_ready high only when idle)
//   resp_*          one-cycle completion pulse with error flag and load data
//   avm_*           Avalon-style master: address/byteenable/read/write/writedata,
//                   waitrequest and readdata from the slave
module mem_access_unit #(
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_error,
   output logic [31:0] resp_rdata,
   output logic [31:0] avm_address,
   output logic [3:0]  avm_byteenable,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ISSUE  = 2'd1;
   localparam logic [1:0] S_RDWAIT = 2'd2;

   localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

   logic [1:0]  state_q, state_d;
   logic [1:0]  off_q, off_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic        write_q, write_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_error_q, resp_error_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic [31:0] avm_address_q, avm_address_d;
   logic [3:0]  avm_be_q, avm_be_d;
   logic [31:0] avm_wd_q, avm_wd_d;

   logic        misaligned;
   logic [3:0]  req_be;
   logic [31:0] req_wd;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_result;

   always_comb begin
      misaligned = 1'b0;
      case (req_size)
         2'd1:    misaligned = req_addr[0];
         2'd2:    misaligned = |req_addr[1:0];
         2'd3:    misaligned = 1'b1;
         default: misaligned = 1'b0;
      endcase
   end

   // Lane placement: stores are replicated across all lanes so the slave
   // picks the right bytes purely from byteenable.
   always_comb begin
      req_be = 4'b1111;
      req_wd = req_wdata;
      case (req_size)
         2'd0: begin
            req_be = 4'b0001 << req_addr[1:0];
            req_wd = {4{req_wdata[7:0]}};
         end
         2'd1: begin
            req_be = 4'b0011 << req_addr[1:0];
            req_wd = {2{req_wdata[15:0]}};
         end
         default: begin
            req_be = 4'b1111;
            req_wd = req_wdata;
         end
      endcase
   end

   always_comb begin
      rd_byte = avm_readdata[7:0];
      case (off_q)
         2'd0:    rd_byte = avm_readdata[7:0];
         2'd1:    rd_byte = avm_readdata[15:8];
         2'd2:    rd_byte = avm_readdata[23:16];
         default: rd_byte = avm_readdata[31:24];
      endcase
      rd_half = off_q[1] ? avm_readdata[31:16] : avm_readdata[15:0];
      load_result = avm_readdata;
      case (size_q)
         2'd0:    load_result = {{24{signed_q & rd_byte[7]}}, rd_byte};
         2'd1:    load_result = {{16{signed_q & rd_half[15]}}, rd_half};
         default: load_result = avm_readdata;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      off_d         = off_q;
      size_d        = size_q;
      signed_d      = signed_q;
      write_d       = write_q;
      cnt_d         = cnt_q;
      resp_valid_d  = 1'b0;
      resp_error_d  = resp_error_q;
      resp_rdata_d  = resp_rdata_q;
      avm_address_d = avm_address_q;
      avm_be_d      = avm_be_q;
      avm_wd_d      = avm_wd_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               off_d    = req_addr[1:0];
               size_d   = req_size;
               signed_d = req_signed;
               write_d  = req_write;
               if (misaligned) begin
                  resp_valid_d = 1'b1;
                  resp_error_d = 1'b1;
                  resp_rdata_d = 32'd0;
               end else begin
                  state_d       = S_ISSUE;
                  avm_address_d = {req_addr[31:2], 2'b00};
                  avm_be_d      = req_be;
                  avm_wd_d      = req_wd;
               end
            end
         end
         S_ISSUE: begin
            if (!avm_waitrequest) begin
               if (write_q) begin
                  state_d      = S_IDLE;
                  resp_valid_d = 1'b1;
                  resp_error_d = 1'b0;
                  resp_rdata_d = 32'd0;
               end else begin
                  state_d = S_RDWAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         S_RDWAIT: begin
            // Counter reaching zero marks the edge where readdata is valid.
            if (cnt_q == 2'd0) begin
               state_d      = S_IDLE;
               resp_valid_d = 1'b1;
               resp_error_d = 1'b0;
               resp_rdata_d = load_result;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         off_q         <= 2'd0;
         size_q        <= 2'd0;
         signed_q      <= 1'b0;
         write_q       <= 1'b0;
         cnt_q         <= 2'd0;
         resp_valid_q  <= 1'b0;
         resp_error_q  <= 1'b0;
         resp_rdata_q  <= 32'd0;
         avm_address_q <= 32'd0;
         avm_be_q      <= 4'd0;
         avm_wd_q      <= 32'd0;
      end else begin
         state_q       <= state_d;
         off_q         <= off_d;
         size_q        <= size_d;
         signed_q      <= signed_d;
         write_q       <= write_d;
         cnt_q         <= cnt_d;
         resp_valid_q  <= resp_valid_d;
         resp_error_q  <= resp_error_d;
         resp_rdata_q  <= resp_rdata_d;
         avm_address_q <= avm_address_d;
         avm_be_q      <= avm_be_d;
         avm_wd_q      <= avm_wd_d;
      end
   end

   // Bus commands depend only on registered state, never on req_* directly.
   assign req_ready      = (state_q == S_IDLE);
   assign avm_read       = (state_q == S_ISSUE) && !write_q;
   assign avm_write      = (state_q == S_ISSUE) && write_q;
   assign avm_address    = avm_address_q;
   assign avm_byteenable = avm_be_q;
   assign avm_writedata  = avm_wd_q;
   assign resp_valid     = resp_valid_q;
   assign resp_error     = resp_error_q;
   assign resp_rdata     = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
`timescale 1ns/1ps
module tb_mem_access_unit;

   localparam int RL = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_write, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, resp_valid, resp_error;
   logic [31:0] resp_rdata, avm_address, avm_writedata;
   logic [3:0]  avm_byteenable;
   logic        avm_read, avm_write;
   logic        avm_waitrequest = 1'b0;
   logic [31:0] avm_readdata = 32'd0;

   logic        req_ready3, resp_valid3, resp_error3;
   logic [31:0] resp_rdata3, avm_address3, avm_writedata3;
   logic [3:0]  avm_byteenable3;
   logic        avm_read3, avm_write3;
   logic [31:0] avm_readdata3 = 32'd0;

   int errors = 0;
   int checks = 0;
   int n_req = 0;
   int resp_cnt = 0;

   logic [31:0] smem [8];
   logic [31:0] rmem [8];

   int          wait_left = 0;
   int          cmd_cycles = 0;
   int          k = 0;
   bit          in_wait = 1'b0;
   bit          acc_pending = 1'b0;
   logic [2:0]  rd_idx = 3'd0;
   logic [31:0] exp_addr = 32'd0, exp_wd = 32'd0;
   logic [3:0]  exp_be = 4'd0;
   logic        exp_w = 1'b0;
   logic [31:0] hold_addr, hold_wd;
   logic [3:0]  hold_be;
   logic [1:0]  hold_dir;

   always #5 clk = ~clk;

   mem_access_unit #(.READ_LATENCY(RL)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
      .avm_address(avm_address), .avm_byteenable(avm_byteenable),
      .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata)
   );

   mem_access_unit #(.READ_LATENCY(3)) u_dut3 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready3), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid3), .resp_error(resp_error3), .resp_rdata(resp_rdata3),
      .avm_address(avm_address3), .avm_byteenable(avm_byteenable3),
      .avm_read(avm_read3), .avm_write(avm_write3), .avm_writedata(avm_writedata3),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                            input logic sgn, input logic [1:0] off);
      logic [31:0] v;
      case (size)
         2'd0: begin
            v = (word >> (8 * off)) & 32'hFF;
            if (sgn && v >= 32'h80) v = v | 32'hFFFFFF00;
         end
         2'd1: begin
            v = (word >> (16 * off[1])) & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v | 32'hFFFF0000;
         end
         default: v = word;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] off, input logic [31:0] wdata);
      logic [31:0] mask, val;
      case (size)
         2'd0: begin
            mask = 32'hFF << (8 * off);
            val  = (wdata & 32'hFF) << (8 * off);
         end
         2'd1: begin
            mask = 32'hFFFF << (16 * off[1]);
            val  = (wdata & 32'hFFFF) << (16 * off[1]);
         end
         default: begin
            mask = 32'hFFFFFFFF;
            val  = wdata;
         end
      endcase
      return (word & ~mask) | val;
   endfunction

   // Avalon slave: stalls for wait_left cycles, then accepts; read data is
   // valid only on the exact edge dictated by the latency, random otherwise.
   always @(negedge clk) begin
      if (acc_pending) begin
         k = 1;
         acc_pending = 1'b0;
      end else if (k != 0 && k < 8) begin
         k = k + 1;
      end
      avm_readdata  = (k == RL) ? smem[rd_idx] : $urandom;
      avm_readdata3 = (k == 3)  ? smem[rd_idx] : $urandom;
      if (avm_read === 1'b1 || avm_write === 1'b1) begin
         cmd_cycles = cmd_cycles + 1;
         if (!in_wait) begin
            chk("cmd_addr", avm_address, exp_addr);
            chk("cmd_be", 32'(avm_byteenable), 32'(exp_be));
            chk("cmd_dir", 32'({avm_write, avm_read}), 32'({exp_w, ~exp_w}));
            if (exp_w) chk("cmd_wdata", avm_writedata, exp_wd);
            hold_addr = avm_address;
            hold_be   = avm_byteenable;
            hold_wd   = avm_writedata;
            hold_dir  = {avm_write, avm_read};
            in_wait   = 1'b1;
         end else begin
            chk("hold_addr", avm_address, hold_addr);
            chk("hold_be", 32'(avm_byteenable), 32'(hold_be));
            chk("hold_wdata", avm_writedata, hold_wd);
            chk("hold_dir", 32'({avm_write, avm_read}), 32'(hold_dir));
         end
         if (wait_left > 0) begin
            avm_waitrequest = 1'b1;
            wait_left = wait_left - 1;
         end else begin
            avm_waitrequest = 1'b0;
            in_wait = 1'b0;
            if (avm_write) begin
               for (int b = 0; b < 4; b++)
                  if (avm_byteenable[b]) smem[avm_address[4:2]][8*b +: 8] = avm_writedata[8*b +: 8];
            end else begin
               acc_pending = 1'b1;
               rd_idx = avm_address[4:2];
            end
         end
      end else begin
         in_wait = 1'b0;
         avm_waitrequest = ($urandom_range(0, 1) == 1);
      end
   end

   always @(negedge clk) begin
      #1;
      if (resp_valid === 1'b1) resp_cnt = resp_cnt + 1;
   end

   task automatic setup(input logic w, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input int waits);
      req_write  = w;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      req_valid  = 1'b1;
      wait_left  = waits;
      cmd_cycles = 0;
      exp_w      = w;
      exp_addr   = {addr[31:2], 2'b00};
      case (size)
         2'd0: begin
            exp_be = 4'(32'd1 << addr[1:0]);
            exp_wd = (wdata & 32'hFF) * 32'h01010101;
         end
         2'd1: begin
            exp_be = 4'(32'd3 << addr[1:0]);
            exp_wd = (wdata & 32'hFFFF) * 32'h00010001;
         end
         default: begin
            exp_be = 4'hF;
            exp_wd = wdata;
         end
      endcase
   endtask

   task automatic do_req(input string tag, input logic w, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input int waits);
      logic        err;
      logic [31:0] exp_rd;
      int          lat;
      int          c;
      bit          done;
      logic [2:0]  idx;
      logic [1:0]  off;
      idx = addr[4:2];
      off = addr[1:0];
      err = (size == 2'd3) || (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0);
      if (err) begin
         exp_rd = 32'd0;
         lat = 0;
      end else if (w) begin
         rmem[idx] = ref_store(rmem[idx], size, off, wdata);
         exp_rd = 32'd0;
         lat = 1 + waits;
      end else begin
         exp_rd = ref_load(rmem[idx], size, sgn, off);
         lat = 1 + waits + RL;
      end
      setup(w, size, sgn, addr, wdata, waits);
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
      @(posedge clk);
      c = 0;
      done = 1'b0;
      while (!done && c < 40) begin
         @(negedge clk);
         if (c == 0) req_valid = 1'b0;
         if (resp_valid === 1'b1) begin
            done = 1'b1;
         end else begin
            chk({tag, "_busy"}, 32'(req_ready), 32'd0);
            c++;
         end
      end
      chk({tag, "_lat"}, 32'(c), 32'(lat));
      chk({tag, "_err"}, 32'(resp_error), 32'(err));
      chk({tag, "_rdata"}, resp_rdata, exp_rd);
      chk({tag, "_ready_at_resp"}, 32'(req_ready), 32'd1);
      chk({tag, "_cmds"}, 32'(cmd_cycles), err ? 32'd0 : 32'(waits + 1));
      n_req++;
   endtask

   initial begin
      logic [31:0] exp3, r3;
      int          c1, c3;
      for (int i = 0; i < 8; i++) smem[i] = $urandom;
      smem[1] = 32'h8899AABB;
      for (int i = 0; i < 8; i++) rmem[i] = smem[i];
      reset = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
      req_addr = 32'd0; req_wdata = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_error", 32'(resp_error), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_avm_read", 32'(avm_read), 32'd0);
      chk("rst_avm_write", 32'(avm_write), 32'd0);
      chk("rst_avm_be", 32'(avm_byteenable), 32'd0);
      chk("rst_avm_addr", avm_address, 32'd0);
      chk("rst_avm_wdata", avm_writedata, 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      reset = 1'b0;
      @(negedge clk);

      do_req("lw", 1'b0, 2'd2, 1'b0, 32'hBFC00004, 32'd0, 0);
      chk("lw_const", resp_rdata, 32'h8899AABB);
      do_req("lb", 1'b0, 2'd0, 1'b1, 32'hBFC00007, 32'd0, 0);
      chk("lb_const", resp_rdata, 32'hFFFFFF88);
      do_req("lbu", 1'b0, 2'd0, 1'b0, 32'hBFC00007, 32'd0, 0);
      chk("lbu_const", resp_rdata, 32'h00000088);
      do_req("lhu", 1'b0, 2'd1, 1'b0, 32'hBFC00004, 32'd0, 0);
      chk("lhu_const", resp_rdata, 32'h0000AABB);
      do_req("lh", 1'b0, 2'd1, 1'b1, 32'hBFC00004, 32'd0, 0);
      chk("lh_const", resp_rdata, 32'hFFFFAABB);

      do_req("sh", 1'b1, 2'd1, 1'b0, 32'hBFC00002, 32'h00001234, 0);
      do_req("lw0", 1'b0, 2'd2, 1'b0, 32'hBFC00000, 32'd0, 0);
      chk("lw0_hi", 32'(resp_rdata[31:16]), 32'h1234);

      do_req("lw_wait", 1'b0, 2'd2, 1'b0, 32'hBFC00004, 32'd0, 3);

      do_req("lw_mis", 1'b0, 2'd2, 1'b0, 32'hBFC00001, 32'd0, 0);
      do_req("sh_mis", 1'b1, 2'd1, 1'b0, 32'hBFC00003, 32'h0000FFFF, 0);
      do_req("size3", 1'b0, 2'd3, 1'b0, 32'hBFC00008, 32'd0, 0);

      // Reset while a read is stalled in the command phase.
      setup(1'b0, 2'd2, 1'b0, 32'hBFC00008, 32'd0, 100);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst_mid_read_before", 32'(avm_read), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_read", 32'(avm_read), 32'd0);
      chk("rst_mid_write", 32'(avm_write), 32'd0);
      chk("rst_mid_resp", 32'(resp_valid), 32'd0);
      chk("rst_mid_ready", 32'(req_ready), 32'd1);
      reset = 1'b0;
      wait_left = 0;
      @(negedge clk);
      chk("rst_mid_no_resp", 32'(resp_valid), 32'd0);

      do_req("sw", 1'b1, 2'd2, 1'b0, 32'hBFC0000C, 32'hCAFEF00D, 0);

      // Both units are synchronised by the reset; the latency-3 one must
      // answer the same load exactly two cycles later.
      exp3 = ref_load(rmem[1], 2'd2, 1'b0, 2'd0);
      setup(1'b0, 2'd2, 1'b0, 32'hBFC00004, 32'd0, 0);
      @(posedge clk);
      c1 = -1;
      c3 = -1;
      r3 = 32'd0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (c == 0) req_valid = 1'b0;
         if (resp_valid === 1'b1 && c1 < 0) c1 = c;
         if (resp_valid3 === 1'b1 && c3 < 0) begin
            c3 = c;
            r3 = resp_rdata3;
         end
      end
      n_req++;
      chk("rl1_lat", 32'(c1), 32'(RL + 1));
      chk("rl1_data", resp_rdata, exp3);
      chk("rl3_lat", 32'(c3), 32'(c1 + 2));
      chk("rl3_data", r3, exp3);

      for (int i = 0; i < 60; i++) begin
         logic [31:0] a;
         a = 32'hBFC00000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         do_req("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                a, $urandom, $urandom_range(0, 2));
      end

      repeat (3) @(negedge clk);
      chk("resp_count", 32'(resp_cnt), 32'(n_req));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
